// File: rtl/seq_control_unit.sv
// seq_control_unit: one-hot pipeline sequencer with stall, flush, halt/resume and retired-instruction counter
module seq_control_unit #(
    parameter int NUM_STAGES = 3,
    parameter int INCR_STAGE = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic                  flush,
    input  logic                  halt_req,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  incr_pc,
    output logic                  instr_done,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired_count,
    output logic [NUM_STAGES:0]   dbg_state
);
    localparam int SW = NUM_STAGES + 1;
    localparam logic [SW-1:0] S0   = SW'(1);
    localparam logic [SW-1:0] HALT = SW'(1) << NUM_STAGES;

    logic [SW-1:0] state, state_nxt;
    logic legal, adv, last;

    // State register; reset parks the unit at fetch
    always_ff @(posedge clk) begin
        if (rst) state <= S0;
        else     state <= state_nxt;
    end

    // Next state: illegal recovery, halt exit, flush, then advance/stall
    always_comb begin
        legal = (state != '0) && ((state & (state - SW'(1))) == '0);
        adv   = legal && |(state[NUM_STAGES-1:0] & stage_ready);
        last  = state[NUM_STAGES-1];
        state_nxt = !legal             ? S0 :
                    state[NUM_STAGES]  ? (halt_req ? HALT : S0) :
                    flush              ? S0 :
                    !adv               ? state :
                    last               ? (halt_req ? HALT : S0) :
                                         state << 1;
    end

    // Outputs: enables mirror the state, strobes only on a clean completion
    always_comb begin
        stage_en   = state[NUM_STAGES-1:0];
        halted     = state[NUM_STAGES];
        dbg_state  = state;
        incr_pc    = !rst && legal && !flush && state[INCR_STAGE] && stage_ready[INCR_STAGE];
        instr_done = !rst && legal && !flush && state[NUM_STAGES-1] && stage_ready[NUM_STAGES-1];
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)             retired_count <= '0;
        else if (instr_done) retired_count <= retired_count + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed stimulus with a behavioural sequencer model checked every cycle
module tb_seq_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // DUT a: 3 stages, PC increment on stage 1, 4-bit counter
    logic       rst3 = 1'b1, flush3 = 1'b0, halt3 = 1'b0;
    logic [2:0] rdy3 = '0;
    logic [2:0] en3;
    logic       incr3, done3, hlt3;
    logic [3:0] cnt3;
    logic [3:0] dbg3;

    // DUT b: 5 stages, PC increment on stage 2, 16-bit counter
    logic        rst5 = 1'b1, flush5 = 1'b0, halt5 = 1'b0;
    logic [4:0]  rdy5 = '0;
    logic [4:0]  en5;
    logic        incr5, done5, hlt5;
    logic [15:0] cnt5;
    logic [5:0]  dbg5;

    seq_control_unit #(.NUM_STAGES(3), .INCR_STAGE(1), .CNT_WIDTH(4)) u3 (
        .clk(clk), .rst(rst3), .stage_ready(rdy3), .flush(flush3), .halt_req(halt3),
        .stage_en(en3), .incr_pc(incr3), .instr_done(done3), .halted(hlt3),
        .retired_count(cnt3), .dbg_state(dbg3)
    );

    seq_control_unit #(.NUM_STAGES(5), .INCR_STAGE(2), .CNT_WIDTH(16)) u5 (
        .clk(clk), .rst(rst5), .stage_ready(rdy5), .flush(flush5), .halt_req(halt5),
        .stage_en(en5), .incr_pc(incr5), .instr_done(done5), .halted(hlt5),
        .retired_count(cnt5), .dbg_state(dbg5)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an instruction is a walk over stage indices; counter counts completions
    task automatic mstep(input int ns, input bit r, input bit f, input bit h, input logic [15:0] rdy,
                         inout int st, inout bit hl, inout int cnt);
        if (r) begin
            st = 0; hl = 0; cnt = 0;
        end else if (hl) begin
            if (!h) begin hl = 0; st = 0; end
        end else if (f) begin
            st = 0;
        end else if (rdy[st]) begin
            if (st == ns - 1) begin
                cnt++;
                if (h) hl = 1; else st = 0;
            end else st++;
        end
    endtask

    int  m3_st = 0, m3_cnt = 0, m5_st = 0, m5_cnt = 0;
    bit  m3_hl = 0, m5_hl = 0, m3_ok = 0, m5_ok = 0;

    always @(posedge clk) begin
        if (rst3) m3_ok = 1;
        if (rst5) m5_ok = 1;
        mstep(3, rst3, flush3, halt3, 16'(rdy3), m3_st, m3_hl, m3_cnt);
        mstep(5, rst5, flush5, halt5, 16'(rdy5), m5_st, m5_hl, m5_cnt);
    end

    // Compare both DUTs against the model on every falling edge
    always @(negedge clk) begin
        logic [4:0] e_en;
        bit live;
        if (m3_ok) begin
            e_en = m3_hl ? 5'd0 : 5'(1 << m3_st);
            live = !rst3 && !flush3 && !m3_hl;
            chk("m3_stage_en", 32'(en3), 32'(e_en[2:0]));
            chk("m3_halted", 32'(hlt3), 32'(m3_hl));
            chk("m3_dbg", 32'(dbg3), 32'({m3_hl, e_en[2:0]}));
            chk("m3_incr", 32'(incr3), 32'(live && m3_st == 1 && rdy3[1]));
            chk("m3_done", 32'(done3), 32'(live && m3_st == 2 && rdy3[2]));
            chk("m3_count", 32'(cnt3), 32'(m3_cnt % 16));
        end
        if (m5_ok) begin
            e_en = m5_hl ? 5'd0 : 5'(1 << m5_st);
            live = !rst5 && !flush5 && !m5_hl;
            chk("m5_stage_en", 32'(en5), 32'(e_en));
            chk("m5_halted", 32'(hlt5), 32'(m5_hl));
            chk("m5_dbg", 32'(dbg5), 32'({m5_hl, e_en}));
            chk("m5_incr", 32'(incr5), 32'(live && m5_st == 2 && rdy5[2]));
            chk("m5_done", 32'(done5), 32'(live && m5_st == 4 && rdy5[4]));
            chk("m5_count", 32'(cnt5), 32'(m5_cnt % 65536));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] en_tab [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rdy3 = 3'b111;
        tick; tick;
        #1;
        chk("rst_en", 32'(en3), 32'h1);
        chk("rst_dbg", 32'(dbg3), 32'h1);
        chk("rst_halted", 32'(hlt3), 32'h0);
        chk("rst_count", 32'(cnt3), 32'h0);
        chk("rst_strobes", 32'({incr3, done3}), 32'h0);
        rst3 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("free_en", 32'(en3), 32'(en_tab[c]));
            chk("free_incr", 32'(incr3), 32'(c % 3 == 1));
            chk("free_done", 32'(done3), 32'(c % 3 == 2));
            tick;
        end
        #1 chk("free_count", 32'(cnt3), 32'd3);

        rdy3 = 3'b110;
        for (int c = 0; c < 5; c++) begin
            #1 chk("stall_en", 32'(en3), 32'h1);
            chk("stall_incr", 32'(incr3), 32'h0);
            tick;
        end
        rdy3 = 3'b111;
        #1 chk("stall_en6", 32'(en3), 32'h1);
        tick;
        rdy3 = 3'b101;
        for (int c = 0; c < 2; c++) begin
            #1 chk("stall1_incr", 32'(incr3), 32'h0);
            tick;
        end
        rdy3 = 3'b111;
        #1 chk("stall1_incr_fire", 32'(incr3), 32'h1);
        tick;
        #1 chk("stall_done", 32'(done3), 32'h1);
        tick;
        #1 chk("stall_count", 32'(cnt3), 32'd4);

        tick; tick;
        flush3 = 1'b1;
        #1 chk("flush_en2", 32'(en3), 32'h4);
        chk("flush_nodone", 32'(done3), 32'h0);
        tick;
        flush3 = 1'b0;
        #1 chk("flush_en0", 32'(en3), 32'h1);
        chk("flush_count", 32'(cnt3), 32'd4);

        tick; tick;
        halt3 = 1'b1;
        #1 chk("halt_done", 32'(done3), 32'h1);
        tick;
        for (int h = 1; h <= 4; h++) begin
            halt3 = (h != 4);
            flush3 = (h == 2);
            #1 chk("halt_halted", 32'(hlt3), 32'h1);
            chk("halt_en", 32'(en3), 32'h0);
            chk("halt_strobes", 32'({incr3, done3}), 32'h0);
            tick;
        end
        flush3 = 1'b0;
        #1 chk("resume_en", 32'(en3), 32'h1);
        chk("resume_halted", 32'(hlt3), 32'h0);
        chk("resume_count", 32'(cnt3), 32'd5);

        rst3 = 1'b1;
        tick;
        rst3 = 1'b0;
        #1 chk("wrap_start", 32'(cnt3), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick; tick; tick;
            #1 chk("wrap_count", 32'(cnt3), 32'(k % 16));
        end

        rst5 = 1'b0;
        rdy5 = 5'b11111;
        tick;
        rst5 = 1'b1;
        #1 chk("r5_strobes1", 32'({incr5, done5}), 32'h0);
        tick;
        rst5 = 1'b0;
        #1 chk("r5_dbg", 32'(dbg5), 32'h01);
        chk("r5_count", 32'(cnt5), 32'd0);
        tick; tick;
        rst5 = 1'b1;
        #1 chk("r5_noincr", 32'(incr5), 32'h0);
        tick;
        rst5 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1 chk("r5_en", 32'(en5), 32'(1 << (c % 5)));
            chk("r5_incr", 32'(incr5), 32'(c % 5 == 2));
            chk("r5_done", 32'(done5), 32'(c % 5 == 4));
            tick;
        end
        #1 chk("r5_count2", 32'(cnt5), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Parametrised one-hot pipeline sequencer that steps the datapath through a configurable number of stages (fetch, decode, ALU, memory, writeback, ...). Each stage holds until its ready handshake, and the unit supports flush-to-fetch, halt/resume at an instruction boundary, and a retired-instruction counter. It sits between the fetch/decode/ALU units and the program counter: it drives per-stage enables and the PC increment strobe, and it exposes its state for debug.

## Interface
- NUM_STAGES, 3, number of pipeline stages; legal range 2..16; stage 0 is fetch.
- INCR_STAGE, 1, index of the stage whose completion increments the PC; must be < NUM_STAGES.
- CNT_WIDTH, 16, width of the retired-instruction counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stage_ready  in  NUM_STAGES  bit i = stage i has finished its work this cycle.
- flush  in  1  abandon the current instruction and restart at stage 0.
- halt_req  in  1  request to stop at the next instruction boundary.
- stage_en  out  NUM_STAGES  one-hot enable of the active stage; all zero when halted.
- incr_pc  out  1  single-cycle PC increment strobe.
- instr_done  out  1  single-cycle strobe when the last stage completes.
- halted  out  1  high while parked in HALT.
- retired_count  out  CNT_WIDTH  number of completed instructions.
- dbg_state  out  NUM_STAGES+1  raw state register; bit NUM_STAGES = HALT.

## Operation
- The state register is one-hot over NUM_STAGES stage states plus one HALT state. stage_en equals the low NUM_STAGES bits of the state, and halted equals the HALT bit.
- The "advance" condition is: the active stage i has stage_ready[i]=1. The stage_ready bits of inactive stages are ignored.
- Stage i < NUM_STAGES-1 with advance moves to stage i+1. Without advance it stays in stage i (stall, unbounded).
- The last stage with advance:
  - moves to HALT if halt_req=1, otherwise to stage 0;
  - asserts instr_done;
  - increments retired_count, wrapping modulo 2^CNT_WIDTH.
- HALT: all stage_en bits are 0 and halted=1. The unit leaves HALT for stage 0 in the cycle after halt_req is sampled 0. stage_ready is ignored in HALT.
- incr_pc = stage_en[INCR_STAGE] & stage_ready[INCR_STAGE]. This gives exactly one pulse per instruction regardless of stall length.
- flush (when not in reset):
  - forces next state to stage 0 from any stage state;
  - takes priority over advance and halt_req;
  - suppresses incr_pc and instr_done in that cycle;
  - leaves retired_count unchanged.
  - flush in HALT has no effect.
- Priority, highest first: rst, flush, halt exit / advance / stall.
- Illegal state (not one-hot, or zero) recovers to stage 0 on the next edge; no strobes are asserted while the state is illegal.

## Timing
- Reset values:
  - state = stage 0, so stage_en = 1 and dbg_state = 1;
  - halted = 0;
  - retired_count = 0;
  - incr_pc and instr_done are 0 while rst=1.
- rst asserted mid-instruction returns the unit to stage 0 on the next edge and discards the in-flight instruction; no strobes are produced.
- Registered state; incr_pc and instr_done are combinational from state and stage_ready in the same cycle as the completing ready.
- Minimum instruction latency is NUM_STAGES cycles, when every stage is ready on its first cycle.
- Back-to-back instructions: stage 0 is re-entered in the cycle after instr_done, with no bubble.
- halt_req is sampled only in the completion cycle of the last stage. A pulse at any other time is lost.
- HALT with halt_req held at 1 holds indefinitely. Minimum halt duration is 1 cycle.
- retired_count updates on the edge ending the instr_done cycle.

## Test plan
- Reset then free-run: NUM_STAGES=3, stage_ready=all 1, 9 cycles.
  - Required: stage_en sequence 001,010,100 repeating.
  - Required: incr_pc high in cycles 2, 5, 8 and instr_done high in cycles 3, 6, 9.
  - Required: retired_count=3 after the last edge.
- Stall: hold stage_ready[0]=0 for 5 cycles after reset, then 1.
  - Required: stage_en stays 001 for 6 cycles.
  - Required: incr_pc fires once, when stage 1 completes.
- Flush: assert flush while in stage 2 with stage_ready[2]=1.
  - Required: next state = stage 0.
  - Required: no instr_done, and retired_count unchanged.
  - Required: flush in HALT leaves halted=1.
- Halt/resume: halt_req=1 during last-stage completion, held for 4 cycles, then 0.
  - Required: instr_done pulses, then halted=1 and stage_en=0 for 4 cycles.
  - Required: stage 0 is entered the cycle after halt_req falls.
- Counter wrap: CNT_WIDTH=4, run 17 instructions.
  - Required: retired_count goes 15→0→1.
- Reset mid-operation and parametrisation: assert rst in stage 1 with NUM_STAGES=5.
  - Required: dbg_state=00001 next cycle, retired_count=0, no strobes.
  - Required: a free-run then shows a 5-cycle stage_en rotation.
